// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups.
// Supports wrapping and saturating add/sub, N/Z/V/C flags and a valid/ready handshake.
module cla_addsub_pipe #(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
);

    localparam int GBITS   = 4 * GROUPS_PER_STAGE;
    localparam int LATENCY = WIDTH / GBITS;

    typedef struct packed {
        logic [1:0]       op;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bx;
        logic [WIDTH-1:0] res;
    } token_t;

    // tok_q[0] holds the accepted operands; tok_q[k] feeds stage k, tok_d[k] is its output
    logic   valid_q [LATENCY];
    token_t tok_q   [LATENCY];
    token_t tok_d   [LATENCY];
    token_t tok_in;

    logic             advance;
    logic [WIDTH-1:0] fin_result;
    logic             fin_v;
    logic             fin_c;
    logic             a_msb;
    logic             bx_msb;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Returns {group generate, group propagate, 4-bit sum}
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]),
                &p, p ^ c};
    endfunction

    always_comb begin
        tok_in.op    = op;
        tok_in.carry = op[0];
        tok_in.a     = a;
        tok_in.bx    = op[0] ? ~b : b;
        tok_in.res   = '0;
    end

    always_comb begin : stage_logic
        logic [5:0]  grp;
        int unsigned lo;
        grp = '0;
        lo  = 0;
        for (int unsigned k = 0; k < LATENCY; k++) begin
            tok_d[k] = tok_q[k];
            for (int unsigned g = 0; g < GROUPS_PER_STAGE; g++) begin
                lo                   = k * GBITS + g * 4;
                grp                  = cla4(tok_q[k].a[lo +: 4], tok_q[k].bx[lo +: 4], tok_d[k].carry);
                tok_d[k].res[lo +: 4] = grp[3:0];
                tok_d[k].carry       = grp[5] | (grp[4] & tok_d[k].carry);
            end
        end
    end

    always_comb begin
        a_msb      = tok_d[LATENCY-1].a[WIDTH-1];
        bx_msb     = tok_d[LATENCY-1].bx[WIDTH-1];
        fin_v      = (a_msb == bx_msb) && (tok_d[LATENCY-1].res[WIDTH-1] != a_msb);
        fin_c      = tok_d[LATENCY-1].carry;
        fin_result = tok_d[LATENCY-1].res;
        if (tok_d[LATENCY-1].op[1] && fin_v) begin
            fin_result = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                valid_q[k] <= 1'b0;
                tok_q[k]   <= '0;
            end
            out_valid <= 1'b0;
            result    <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flag_v    <= 1'b0;
            flag_c    <= 1'b0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                tok_q[0] <= tok_in;
            end
            for (int unsigned k = 1; k < LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                if (valid_q[k-1]) begin
                    tok_q[k] <= tok_d[k-1];
                end
            end
            out_valid <= valid_q[LATENCY-1];
            if (valid_q[LATENCY-1]) begin
                result <= fin_result;
                flag_n <= fin_result[WIDTH-1];
                flag_z <= (fin_result == '0);
                flag_v <= fin_v;
                flag_c <= fin_c;
            end
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed bench for cla_addsub_pipe: default 16-bit instance plus a 32-bit,
// one-group-per-stage instance; expected values are hand-computed constants.
module tb_cla_addsub_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // 16-bit instance (LATENCY 2)
    logic        in_valid16 = 1'b0;
    logic        in_ready16;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [1:0]  op16 = '0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [15:0] result16;
    logic        n16, z16, v16, c16;

    // 32-bit instance (LATENCY 8)
    logic        in_valid32 = 1'b0;
    logic        in_ready32;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic [1:0]  op32 = '0;
    logic        out_valid32;
    logic        out_ready32 = 1'b1;
    logic [31:0] result32;
    logic        n32, z32, v32, c32;

    cla_addsub_pipe dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .op(op16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16),
        .flag_n(n16), .flag_z(z16), .flag_v(v16), .flag_c(c16)
    );

    cla_addsub_pipe #(.WIDTH(32), .GROUPS_PER_STAGE(1)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .op(op32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .result(result32),
        .flag_n(n32), .flag_z(z32), .flag_v(v32), .flag_c(c32)
    );

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, SADD = 2'b10, SSUB = 2'b11;

    // Stream vectors: op, a, b, expected result, expected {N,Z,V,C}
    logic [1:0]  s_op  [5] = '{ADD, SUB, SADD, SSUB, ADD};
    logic [15:0] s_a   [5] = '{16'h1111, 16'h0005, 16'h4000, 16'h9000, 16'hA5A5};
    logic [15:0] s_b   [5] = '{16'h2222, 16'h0007, 16'h4000, 16'h7000, 16'h5A5B};
    logic [15:0] s_res [5] = '{16'h3333, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0000};
    logic [3:0]  s_flg [5] = '{4'b0000, 4'b1000, 4'b0010, 4'b1011, 4'b0101};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run16(input string tag, input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] er, input logic [3:0] ef);
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(in_ready16), 32'd1);
        in_valid16 = 1'b1; op16 = o; a16 = x; b16 = y;
        @(posedge clk);
        #1 in_valid16 = 1'b0;
        for (int i = 0; i <= 2; i++) begin
            @(negedge clk);
            if (i < 2) check({tag, ".early"}, 32'(out_valid16), 32'd0);
        end
        check({tag, ".valid"}, 32'(out_valid16), 32'd1);
        check({tag, ".result"}, 32'(result16), 32'(er));
        check({tag, ".nzvc"}, 32'({n16, z16, v16, c16}), 32'(ef));
    endtask

    task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] er, input logic [3:0] ef);
        @(negedge clk);
        in_valid32 = 1'b1; op32 = o; a32 = x; b32 = y;
        @(posedge clk);
        #1 in_valid32 = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) check({tag, ".early"}, 32'(out_valid32), 32'd0);
        end
        check({tag, ".valid"}, 32'(out_valid32), 32'd1);
        check({tag, ".result"}, result32, er);
        check({tag, ".nzvc"}, 32'({n32, z32, v32, c32}), 32'(ef));
    endtask

    initial begin
        int iidx;
        int oidx;
        logic acc;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst16.valid", 32'(out_valid16), 32'd0);
        check("rst16.result", 32'(result16), 32'd0);
        check("rst16.nzvc", 32'({n16, z16, v16, c16}), 32'd0);
        check("rst16.in_ready", 32'(in_ready16), 32'd1);
        check("rst32.valid", 32'(out_valid32), 32'd0);
        check("rst32.result", result32, 32'd0);

        run16("add_ovf",   ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b1010);
        run16("sadd_ovf",  SADD, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b0010);
        run16("sub_ovf",   SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
        run16("ssub_ovf",  SSUB, 16'h8000, 16'h0001, 16'h8000, 4'b1011);
        run16("sub_zero",  SUB,  16'h1234, 16'h1234, 16'h0000, 4'b0101);
        run16("add_x8",    ADD,  16'h00FF, 16'h0001, 16'h0100, 4'b0000);
        run16("add_wrap",  ADD,  16'hFFFF, 16'h0001, 16'h0000, 4'b0101);
        run16("sub_borrow", SUB, 16'h0001, 16'h0002, 16'hFFFF, 4'b1000);
        run16("sadd_neg",  SADD, 16'h8000, 16'h8000, 16'h8000, 4'b1011);
        run16("add_grp",   ADD,  16'h0F0F, 16'h00F1, 16'h1000, 4'b0000);

        // Back-to-back stream with a 3-cycle output stall
        iidx = 0;
        oidx = 0;
        @(negedge clk);
        in_valid16 = 1'b1; op16 = s_op[0]; a16 = s_a[0]; b16 = s_b[0];
        for (int c = 0; c < 40 && oidx < 5; c++) begin
            if (c > 0) @(negedge clk);
            out_ready16 = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            #1;
            if (!out_ready16) begin
                check("stall.in_ready", 32'(in_ready16), 32'd0);
                check("stall.valid", 32'(out_valid16), 32'd1);
                check("stall.result", 32'(result16), 32'(s_res[oidx]));
                check("stall.nzvc", 32'({n16, z16, v16, c16}), 32'(s_flg[oidx]));
            end else if (out_valid16) begin
                check("stream.result", 32'(result16), 32'(s_res[oidx]));
                check("stream.nzvc", 32'({n16, z16, v16, c16}), 32'(s_flg[oidx]));
                oidx++;
            end
            acc = in_valid16 && in_ready16;
            @(posedge clk);
            #1;
            if (acc) begin
                iidx++;
                if (iidx < 5) begin
                    op16 = s_op[iidx]; a16 = s_a[iidx]; b16 = s_b[iidx];
                end else begin
                    in_valid16 = 1'b0;
                end
            end
        end
        out_ready16 = 1'b1;
        check("stream.count", 32'(oidx), 32'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stream.no_dup", 32'(out_valid16), 32'd0);
        end

        // Asynchronous reset with two tokens in flight
        @(negedge clk);
        in_valid16 = 1'b1; op16 = ADD; a16 = 16'h0001; b16 = 16'h0001;
        @(posedge clk);
        #1 a16 = 16'h0002; b16 = 16'h0002;
        @(posedge clk);
        #1 in_valid16 = 1'b0;
        @(posedge clk);
        #1;
        check("flight.valid", 32'(out_valid16), 32'd1);
        check("flight.result", 32'(result16), 32'h0002);
        #1 rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(out_valid16), 32'd0);
        check("arst.result", 32'(result16), 32'd0);
        check("arst.nzvc", 32'({n16, z16, v16, c16}), 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arst.flushed", 32'(out_valid16), 32'd0);
        end
        run16("post_rst", ADD, 16'h0003, 16'h0004, 16'h0007, 4'b0000);

        run32("w32_wrap", ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0101);
        run32("w32_sadd", SADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
